multicycle_main_control: RTL and testbench

- Multicycle main control FSM for the RISC-V core. It is the instruction-decode end of the ALUOp/Funct interface.
- It latches the fetched instruction, sequences FETCH/DECODE/EXEC/MEM/WB, and drives ALUOp and Funct toward the ALU control decoder.
- It also drives all datapath enables and handshakes with instruction and data memory.
- Supported subset: R-type add/sub/and/or, ld, sd, beq. Anything else traps.

---
 rtl/multicycle_main_control.sv | 168 ++++++++++++++++
 tb/tb_multicycle_main_control.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM: latches the fetched instruction, sequences
// FETCH/DECODE/EXEC/MEM/WB and drives ALUOp/Funct plus all datapath enables.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_FETCH  | request instruction, latch ir and bump PC on imem_valid
// S_DECODE | legality check of ir
// S_EXEC   | ALU operation; beq resolves and retires here
// S_MEM    | hold dmem_re/dmem_we until dmem_ready
// S_WB     | one-cycle register file write
// S_TRAP   | illegal instruction, absorbing until reset
module multicycle_main_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    input  logic             imem_valid,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_re,
    output logic             dmem_we,
    input  logic             dmem_ready,
    input  logic             zero,
    output logic [31:0]      ir,
    output logic [1:0]       ALUOp,
    output logic [3:0]       Funct,
    output logic             ALUSrc,
    output logic             reg_we,
    output logic             mem_to_reg,
    output logic             pc_we,
    output logic             pc_src,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [CNT_W-1:0] INSTRET_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] funct;
    logic       is_r, is_ld, is_sd, is_beq;
    logic       r_ok, legal, retire;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct  = {ir_q[30], ir_q[14:12]};
    assign is_r   = (opcode == OP_R);
    assign is_ld  = (opcode == OP_LD);
    assign is_sd  = (opcode == OP_SD);
    assign is_beq = (opcode == OP_BEQ);

    // R-type: funct7 must be 0000000 or 0100000 (sub only), and op in add/sub/and/or
    assign r_ok  = is_r && ({ir_q[31], ir_q[29:25]} == 6'b0) &&
                   ((funct == 4'b0000) || (funct == 4'b1000) ||
                    (funct == 4'b0111) || (funct == 4'b0110));
    assign legal = r_ok ||
                   (is_ld  && (funct3 == 3'b011)) ||
                   (is_sd  && (funct3 == 3'b011)) ||
                   (is_beq && (funct3 == 3'b000));

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        instret_d  = instret_q;
        retire     = 1'b0;
        imem_req   = 1'b0;
        dmem_re    = 1'b0;
        dmem_we    = 1'b0;
        ALUOp      = 2'b00;
        ALUSrc     = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (is_r) begin
                    ALUOp   = 2'b10;
                    state_d = S_WB;
                end else if (is_beq) begin
                    ALUOp   = 2'b01;
                    pc_we   = zero;
                    pc_src  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    ALUSrc  = 1'b1;
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                ALUSrc  = 1'b1;
                dmem_re = is_ld;
                dmem_we = is_sd;
                if (dmem_ready) begin
                    if (is_ld) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = is_ld;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (retire) begin
            instret_d = instret_q + INSTRET_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= 32'h0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
        end
    end

    assign ir      = ir_q;
    assign Funct   = funct;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: an instruction-level model
// predicts every cycle's outputs, plus literal checks on key values.
module tb_multicycle_main_control;

    localparam int C_R   = 0;
    localparam int C_LD  = 1;
    localparam int C_SD  = 2;
    localparam int C_BEQ = 3;
    localparam int C_BAD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        dmem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        imem_req, dmem_re, dmem_we, ALUSrc, reg_we, mem_to_reg;
    logic        pc_we, pc_src, illegal;
    logic [31:0] ir;
    logic [1:0]  ALUOp;
    logic [3:0]  Funct;
    logic [31:0] instret;

    multicycle_main_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .zero(zero), .ir(ir), .ALUOp(ALUOp), .Funct(Funct), .ALUSrc(ALUSrc),
        .reg_we(reg_we), .mem_to_reg(mem_to_reg), .pc_we(pc_we),
        .pc_src(pc_src), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state and per-cycle expectations
    logic        chk_en = 1'b0;
    logic [31:0] ir_exp = 32'h0;
    logic [31:0] instret_exp = 32'h0;
    logic        e_imem_req, e_dmem_re, e_dmem_we, e_alusrc, e_reg_we;
    logic        e_mem_to_reg, e_pc_we, e_pc_src, e_illegal;
    logic [1:0]  e_aluop;

    // snapshots taken at the negedge of the most recent cycle
    logic [1:0]  snap_aluop;
    logic [3:0]  snap_funct;
    logic        snap_pc_we, snap_dmem_re, snap_dmem_we, snap_illegal, snap_imem_req;
    logic [1:0]  exec_aluop;
    logic [3:0]  exec_funct;
    logic        exec_pc_we;
    int          mem_act_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [31:0] w);
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        if (op == 7'h33) begin
            if (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd7)) return C_R;
            if (f7 == 7'h20 && f3 == 3'd0) return C_R;
            return C_BAD;
        end
        if (op == 7'h03 && f3 == 3'd3) return C_LD;
        if (op == 7'h23 && f3 == 3'd3) return C_SD;
        if (op == 7'h63 && f3 == 3'd0) return C_BEQ;
        return C_BAD;
    endfunction

    task automatic exp_idle();
        e_imem_req = 0; e_dmem_re = 0; e_dmem_we = 0; e_alusrc = 0; e_reg_we = 0;
        e_mem_to_reg = 0; e_pc_we = 0; e_pc_src = 0; e_illegal = 0; e_aluop = 2'b00;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req",   {31'b0, imem_req},   {31'b0, e_imem_req});
            chk("dmem_re",    {31'b0, dmem_re},    {31'b0, e_dmem_re});
            chk("dmem_we",    {31'b0, dmem_we},    {31'b0, e_dmem_we});
            chk("ALUSrc",     {31'b0, ALUSrc},     {31'b0, e_alusrc});
            chk("reg_we",     {31'b0, reg_we},     {31'b0, e_reg_we});
            chk("mem_to_reg", {31'b0, mem_to_reg}, {31'b0, e_mem_to_reg});
            chk("pc_we",      {31'b0, pc_we},      {31'b0, e_pc_we});
            chk("pc_src",     {31'b0, pc_src},     {31'b0, e_pc_src});
            chk("illegal",    {31'b0, illegal},    {31'b0, e_illegal});
            chk("ALUOp",      {30'b0, ALUOp},      {30'b0, e_aluop});
            chk("Funct",      {28'b0, Funct},      {28'b0, ir_exp[30], ir_exp[14:12]});
            chk("ir",         ir,                  ir_exp);
            chk("instret",    instret,             instret_exp);
        end
    end

    task automatic cycle();
        @(negedge clk);
        snap_aluop    = ALUOp;
        snap_funct    = Funct;
        snap_pc_we    = pc_we;
        snap_dmem_re  = dmem_re;
        snap_dmem_we  = dmem_we;
        snap_illegal  = illegal;
        snap_imem_req = imem_req;
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH to retire/trap/reset, driving inputs and model.
    task automatic run_instr(input logic [31:0] w, input int fwait, input int mwait,
                             input logic zv, input int trap_cycles, input int rst_at);
        int c;
        c = classify(w);
        mem_act_cnt = 0;
        for (int i = 0; i <= fwait; i++) begin
            exp_idle();
            imem_valid = (i == fwait);
            imem_rdata = (i == fwait) ? w : 32'hFFFF_FFFF;
            dmem_ready = 1'b1;
            zero       = 1'b1;
            e_imem_req = 1'b1;
            e_pc_we    = (i == fwait);
            cycle();
        end
        ir_exp     = w;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        exp_idle();
        cycle();
        if (c == C_BAD) begin
            for (int i = 0; i < trap_cycles; i++) begin
                exp_idle();
                e_illegal  = 1'b1;
                imem_valid = i[0];
                imem_rdata = w ^ 32'h55;
                dmem_ready = ~i[0];
                cycle();
            end
            return;
        end
        exp_idle();
        zero       = zv;
        e_aluop    = (c == C_R) ? 2'b10 : ((c == C_BEQ) ? 2'b01 : 2'b00);
        e_alusrc   = (c == C_LD || c == C_SD);
        e_pc_we    = (c == C_BEQ) && zv;
        e_pc_src   = (c == C_BEQ);
        cycle();
        exec_aluop = snap_aluop;
        exec_funct = snap_funct;
        exec_pc_we = snap_pc_we;
        if (c == C_BEQ) begin
            instret_exp++;
            return;
        end
        if (c == C_LD || c == C_SD) begin
            for (int i = 0; i <= mwait; i++) begin
                exp_idle();
                zero       = ~zero;
                dmem_ready = (i == mwait) && (i != rst_at);
                reset      = (i == rst_at);
                e_alusrc   = 1'b1;
                e_dmem_re  = (c == C_LD);
                e_dmem_we  = (c == C_SD);
                cycle();
                if (snap_dmem_re || snap_dmem_we) mem_act_cnt++;
                if (i == rst_at) begin
                    reset       = 1'b0;
                    ir_exp      = 32'h0;
                    instret_exp = 32'h0;
                    return;
                end
            end
            if (c == C_SD) begin
                instret_exp++;
                return;
            end
        end
        exp_idle();
        dmem_ready   = 1'b1;
        e_reg_we     = 1'b1;
        e_mem_to_reg = (c == C_LD);
        cycle();
        instret_exp++;
    endtask

    task automatic do_reset(input int n);
        chk_en = 1'b0;
        reset  = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset       = 1'b0;
        ir_exp      = 32'h0;
        instret_exp = 32'h0;
        chk_en      = 1'b1;
    endtask

    // One idle FETCH cycle right after a reset, with literal expectations.
    task automatic post_reset_check(input string tag);
        exp_idle();
        e_imem_req = 1'b1;
        imem_valid = 1'b0;
        dmem_ready = 1'b1;
        cycle();
        chk({tag, "_imem_req"}, {31'b0, snap_imem_req}, 32'd1);
        chk({tag, "_dmem_we"},  {31'b0, snap_dmem_we},  32'd0);
        chk({tag, "_illegal"},  {31'b0, snap_illegal},  32'd0);
        chk({tag, "_pc_we"},    {31'b0, snap_pc_we},    32'd0);
        chk({tag, "_ir"},       ir,                     32'h0);
        chk({tag, "_instret"},  instret,                32'd0);
    endtask

    initial begin
        do_reset(3);
        post_reset_check("rst0");

        run_instr(32'h002081B3, 2, 0, 1'b0, 0, -1);   // add
        chk("add_aluop", {30'b0, exec_aluop}, 32'h2);
        chk("add_funct", {28'b0, exec_funct}, 32'h0);
        chk("add_instret", instret, 32'd1);

        run_instr(32'h402081B3, 0, 0, 1'b0, 0, -1);   // sub
        chk("sub_funct", {28'b0, exec_funct}, 32'h8);
        run_instr(32'h0020E1B3, 1, 0, 1'b0, 0, -1);   // or
        chk("or_funct", {28'b0, exec_funct}, 32'h6);
        chk("or_instret", instret, 32'd3);

        run_instr(32'h0080B283, 0, 3, 1'b0, 0, -1);   // ld, ready after 3 waits
        chk("ld_aluop", {30'b0, exec_aluop}, 32'h0);
        chk("ld_re_cycles", mem_act_cnt, 32'd4);
        chk("ld_instret", instret, 32'd4);

        run_instr(32'h0050B423, 0, 2, 1'b0, 0, -1);   // sd
        chk("sd_we_cycles", mem_act_cnt, 32'd3);
        chk("sd_instret", instret, 32'd5);

        run_instr(32'h00208463, 0, 0, 1'b1, 0, -1);   // beq taken
        chk("beq_aluop", {30'b0, exec_aluop}, 32'h1);
        chk("beq_t_pc_we", {31'b0, exec_pc_we}, 32'd1);
        run_instr(32'h00208463, 0, 0, 1'b0, 0, -1);   // beq not taken
        chk("beq_nt_pc_we", {31'b0, exec_pc_we}, 32'd0);
        chk("beq_instret", instret, 32'd7);

        run_instr(32'h022081B3, 0, 0, 1'b0, 5, -1);   // funct7=0000001 traps
        chk("trap1_illegal", {31'b0, snap_illegal}, 32'd1);
        chk("trap1_instret", instret, 32'd7);
        do_reset(1);
        post_reset_check("rst1");

        run_instr(32'h00000000, 0, 0, 1'b0, 22, -1);
        chk("trap0_illegal", {31'b0, snap_illegal}, 32'd1);
        chk("trap0_imem_req", {31'b0, snap_imem_req}, 32'd0);
        do_reset(1);
        post_reset_check("rst2");

        run_instr(32'h002081B3, 0, 0, 1'b0, 0, -1);   // add so instret is nonzero
        chk("pre_abort_instret", instret, 32'd1);
        run_instr(32'h0050B423, 0, 3, 1'b0, 0, 1);    // sd, reset during MEM
        post_reset_check("rst_mem");

        run_instr(32'h0080B283, 1, 0, 1'b0, 0, -1);   // ld zero-wait
        run_instr(32'h0020F1B3, 0, 0, 1'b0, 0, -1);   // and
        chk("final_instret", instret, 32'd2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
